// File: rtl/main_stream_pkg.sv
// Shared definitions for the main_stream kernel wrapper: default word width,
// kernel word type and an elaboration-time ceil(log2) helper.
package main_stream_pkg;

    localparam int DATAW_DEF = 32;

    typedef logic [DATAW_DEF-1:0] kword_t;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/main_kernelTop.sv
// Kernel model: sum of all input channels, emerging after KLAT non-stalled edges.
// The whole pipeline freezes while stall is high (global-stall contract).
module main_kernelTop
    import main_stream_pkg::*;
#(
    parameter int DATAW = DATAW_DEF,
    parameter int NIN   = 2,
    parameter int KLAT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [NIN*DATAW-1:0] kt_vin,
    output logic [DATAW-1:0]     kt_vout
);

    logic [DATAW-1:0] stage_q [KLAT];
    logic [DATAW-1:0] stage_d [KLAT];
    logic [DATAW-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NIN; i++) begin
            sum = sum + kt_vin[i*DATAW +: DATAW];
        end
        stage_d = stage_q;
        if (!stall) begin
            stage_d[0] = sum;
            for (int k = 1; k < KLAT; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < KLAT; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign kt_vout = stage_q[KLAT-1];

endmodule

// File: rtl/main_stream_fifo.sv
// Output FIFO with registered head (out_valid/out_data); pointers wrap at DEPTH,
// so non-power-of-two depths are fine.
module main_stream_fifo
    import main_stream_pkg::*;
#(
    parameter int DATAW = DATAW_DEF,
    parameter int DEPTH = 8,
    parameter int AW    = clog2_f(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DATAW-1:0] wr_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    output logic [AW-1:0]    count
);

    localparam int PW = (clog2_f(DEPTH) < 1) ? 1 : clog2_f(DEPTH);

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [DATAW-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             ov_q, ov_d;
    logic [DATAW-1:0] od_q, od_d;
    logic             pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop_ok   = pop && ov_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        cnt_d = cnt_q + AW'(push) - AW'(pop_ok);
        ov_d  = (cnt_d != '0);
        // mem_d already holds this cycle's write, which covers the empty-to-one bypass
        od_d  = mem_d[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ov_q     <= 1'b0;
            od_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ov_q     <= ov_d;
            od_q     <= od_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign count     = cnt_q;

endmodule

// File: rtl/main_stream_top.sv
// Joins NIN valid/ready streams into the kernel, tracks in-flight words with a valid
// shift register and only issues when the output FIFO is guaranteed room (credit).
module main_stream_top
    import main_stream_pkg::*;
#(
    parameter  int DATAW = DATAW_DEF,
    parameter  int NIN   = 2,
    parameter  int KLAT  = 4,
    parameter  int DEPTH = 8,
    localparam int AW    = clog2_f(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [NIN-1:0]       in_valid,
    output logic [NIN-1:0]       in_ready,
    input  logic [NIN*DATAW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAW-1:0]     out_data,
    output logic [AW-1:0]        occupancy
);

    generate
        if (DEPTH < KLAT + 1) begin : g_bad_depth
            $error("main_stream_top: DEPTH must be at least KLAT+1");
        end
    endgenerate

    logic [KLAT-1:0]  vsr_q, vsr_d;
    logic [AW-1:0]    occ_q, occ_d;
    logic [AW-1:0]    fifo_cnt, fifo_cnt_nxt, vsr_cnt;
    logic             room, fire, adv, push, pop;
    logic [DATAW-1:0] kt_vout;

    always_comb begin
        vsr_cnt = AW'($countones(vsr_q));
        // Registered count ignores a same-cycle pop: conservative, never overfills
        room    = !rst && !stall &&
                  (({1'b0, fifo_cnt} + {1'b0, vsr_cnt}) < (AW+1)'(DEPTH));
        fire    = room && (&in_valid);
        adv     = room && (fire || (vsr_q != '0));
        push    = adv && vsr_q[KLAT-1];
        pop     = out_valid && out_ready;
        vsr_d   = vsr_q;
        if (adv) begin
            vsr_d = (vsr_q << 1) | KLAT'(fire);
        end
        fifo_cnt_nxt = fifo_cnt + AW'(push) - AW'(pop);
        occ_d        = fifo_cnt_nxt + AW'($countones(vsr_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsr_q <= '0;
            occ_q <= '0;
        end else begin
            vsr_q <= vsr_d;
            occ_q <= occ_d;
        end
    end

    assign in_ready  = {NIN{fire}};
    assign occupancy = occ_q;

    main_kernelTop #(
        .DATAW (DATAW),
        .NIN   (NIN),
        .KLAT  (KLAT)
    ) u_kernel (
        .clk     (clk),
        .rst     (rst),
        .stall   (!adv),
        .kt_vin  (in_data),
        .kt_vout (kt_vout)
    );

    main_stream_fifo #(
        .DATAW (DATAW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .wr_data   (kt_vout),
        .pop       (pop),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (fifo_cnt)
    );

endmodule

// File: tb/tb_main_stream_top.sv
// Scoreboard bench for main_stream_top: drivers push expected sums, a negedge
// monitor pops and compares whenever the DUT hands out a word.
module tb_main_stream_top;
    import main_stream_pkg::*;

    localparam int DATAW = 32;
    localparam int NIN   = 2;
    localparam int KLAT  = 4;
    localparam int DEPTH = 8;
    localparam int AW    = clog2_f(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 stall = 1'b0;
    logic [NIN-1:0]       in_valid = '0;
    logic [NIN-1:0]       in_ready;
    logic [NIN*DATAW-1:0] in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [DATAW-1:0]     out_data;
    logic [AW-1:0]        occupancy;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     pop_total = 0;
    int     mark_pops = 0;
    int     first_pop_cyc = 0;
    int     last_pop_cyc = 0;
    kword_t exp_q[$];
    kword_t va = 32'd100;
    kword_t vb = 32'd1000;

    main_stream_top #(
        .DATAW (DATAW),
        .NIN   (NIN),
        .KLAT  (KLAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (pop_total == mark_pops) first_pop_cyc = cyc;
            pop_total++;
            last_pop_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d expected none", out_data);
            end else begin
                kword_t e;
                e = exp_q.pop_front();
                chk("scoreboard_data", out_data, e);
            end
        end
    end

    task automatic send(input kword_t a, input kword_t b, output int waits);
        bit ok;
        ok = 0;
        waits = 0;
        in_valid = 2'b11;
        in_data  = {b, a};
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready == 2'b11) begin
                ok = 1;
                break;
            end
            waits++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no handshake expected one");
        end else begin
            exp_q.push_back(a + b);
        end
        @(posedge clk);
        #1;
        in_valid = 2'b00;
    endtask

    task automatic stream(input int ncyc, input int st_from, input int st_len,
                          output int acc, output int bad_ready);
        acc = 0;
        bad_ready = 0;
        for (int c = 0; c < ncyc; c++) begin
            stall    = (c >= st_from) && (c < st_from + st_len);
            in_valid = 2'b11;
            in_data  = {vb, va};
            @(negedge clk);
            if (stall && in_ready != 2'b00) bad_ready++;
            if (in_ready == 2'b11) begin
                exp_q.push_back(va + vb);
                acc++;
                va = va + 1;
                vb = vb + 2;
            end
            @(posedge clk);
            #1;
        end
        stall    = 1'b0;
        in_valid = 2'b00;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid && occupancy == '0) begin
                ok = 1;
                break;
            end
        end
        chk("drain_complete", ok, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, acc, bad, lat, tw, nbad;

        // 1: reset with both inputs valid
        rst = 1'b1;
        in_valid = 2'b11;
        in_data = {32'd9, 32'd9};
        repeat (2) begin
            @(negedge clk);
            chk("reset_in_ready", in_ready, 0);
            chk("reset_out_valid", out_valid, 0);
            chk("reset_occupancy", occupancy, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 2'b00;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 2: single pair, latency
        out_ready = 1'b1;
        send(32'd5, 32'd7, w);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                chk("single_data", out_data, 12);
                break;
            end
        end
        chk("single_latency", lat, KLAT + 1);
        @(negedge clk);
        chk("single_valid_once", out_valid, 0);
        @(posedge clk);
        #1;
        wait_drain();

        // 3: 20 back-to-back pairs
        mark_pops = pop_total;
        tw = 0;
        for (int i = 0; i < 20; i++) begin
            send(kword_t'(i), kword_t'(i), w);
            tw += w;
        end
        wait_drain();
        chk("b2b_ready_drops", tw, 0);
        chk("b2b_count", pop_total - mark_pops, 20);
        chk("b2b_one_per_cycle", last_pop_cyc - first_pop_cyc, 19);

        // 4: backpressure fills exactly DEPTH credits
        out_ready = 1'b0;
        stream(20, 0, 0, acc, bad);
        chk("bp_accepted", acc, 8);
        in_valid = 2'b11;
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_occupancy", occupancy, 8);
        @(posedge clk);
        #1;
        in_valid = 2'b00;
        out_ready = 1'b1;
        stream(30, 0, 0, acc, bad);
        chk("bp_resume_accepted", acc, 29);
        wait_drain();

        // 5: partial valid waits for the join
        nbad = 0;
        in_valid = 2'b01;
        in_data = {32'd4, 32'd3};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (in_ready != 2'b00) nbad++;
            @(posedge clk);
            #1;
        end
        chk("join_wait_ready", nbad, 0);
        send(32'd3, 32'd4, w);
        chk("join_accept_wait", w, 0);
        wait_drain();

        // 6: host stall with FIFO draining, then reset with words in flight
        out_ready = 1'b0;
        stream(6, 0, 0, acc, bad);
        chk("stall_prefill", acc, 6);
        chk("stall_pre_occ", occupancy, 6);
        out_ready = 1'b1;
        mark_pops = pop_total;
        stream(5, 0, 5, acc, bad);
        chk("stall_accepted", acc, 0);
        chk("stall_in_ready", bad, 0);
        chk("stall_drain_pops", pop_total - mark_pops, 2);
        chk("stall_occ", occupancy, 4);
        stream(10, 0, 0, acc, bad);
        chk("post_stall_accepted", acc, 10);
        wait_drain();

        send(32'd1, 32'd2, w);
        send(32'd3, 32'd4, w);
        send(32'd5, 32'd6, w);
        chk("inflight_occ", occupancy, 3);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nbad = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid || occupancy != '0) nbad++;
        end
        chk("post_reset_quiet", nbad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
